pc_sequencer: RTL and testbench

Instruction-cycle controller that owns the 16-bit program counter and sequences it through fetch and execute phases. It replaces free-running PC increment with a power-gated state machine: it waits for the instruction-memory handshake, holds while the instruction executes, and then selects the next PC (increment, jump target, or hold on halt). It sits between the instruction memory port and the execute stage at the top of the CPU datapath.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/fetch_watchdog.sv | 37 +++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding, PC width, reset vector.
package pc_seq_pkg;

    localparam int unsigned PcWidth = 16;

    typedef logic [PcWidth-1:0] pc_t;
    typedef logic [1:0]         state_t;

    localparam state_t StOff   = 2'd0;
    localparam state_t StFetch = 2'd1;
    localparam state_t StExec  = 2'd2;
    localparam state_t StHalt  = 2'd3;

    localparam pc_t DefaultResetVector = 16'h0000;

    // Sequential next-PC; wraps modulo 2^PcWidth with no carry out.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch-stall watchdog: counts consecutive stalled FETCH cycles and flags the timeout cycle.
// Only built when PC_SEQ_WATCHDOG_EN is defined.
`ifdef PC_SEQ_WATCHDOG_EN
module fetch_watchdog #(
    parameter int unsigned Timeout = 15
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int unsigned    CntW   = $clog2(Timeout + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Timeout);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Any non-stalled cycle (or leaving FETCH) restarts the count from zero.
    always_comb begin
        cnt_d = '0;
        if (stall_i) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = stall_i && (cnt_q == CntMax);

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller owning the PC: OFF -> FETCH -> EXEC -> (FETCH | HALT).
// Optional fetch watchdog enabled by defining PC_SEQ_WATCHDOG_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter pc_t ResetVector = DefaultResetVector
`ifdef PC_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned FetchTimeout = 15
`endif
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               is_powered_on_i,
    input  logic               mem_ready_i,
    input  logic               exec_done_i,
    input  logic               jump_en_i,
    input  logic [PcWidth-1:0] jump_target_i,
    input  logic               halt_i,
    output logic               fetch_req_o,
    output logic [PcWidth-1:0] fetch_addr_o,
    output logic               instr_valid_o,
    output logic [PcWidth-1:0] pc_o,
    output logic [1:0]         state_o,
    output logic               halted_o,
    output logic               fetch_fault_o
);

    state_t state_q, state_d;
    pc_t    pc_q, pc_d;
    logic   instr_valid_q, instr_valid_d;
    logic   timeout;

`ifdef PC_SEQ_WATCHDOG_EN
    logic fault_q, fault_d;

    fetch_watchdog #(
        .Timeout (FetchTimeout)
    ) u_fetch_watchdog (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .stall_i   (state_q == StFetch && !mem_ready_i),
        .timeout_o (timeout)
    );

    // Sticky until power-off; timeout already excludes a same-cycle mem_ready.
    always_comb begin
        fault_d = fault_q;
        if (!is_powered_on_i) begin
            fault_d = 1'b0;
        end else if (timeout) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault_o = fault_q;
`else
    assign timeout       = 1'b0;
    assign fetch_fault_o = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = 1'b0;
        if (!is_powered_on_i) begin
            state_d = StOff;
            pc_d    = ResetVector;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (mem_ready_i) begin
                        state_d       = StExec;
                        instr_valid_d = 1'b1;
                    end else if (timeout) begin
                        state_d = StHalt;
                    end
                end
                StExec: begin
                    // halt outranks jump_en; both are don't-care without exec_done.
                    if (exec_done_i) begin
                        if (halt_i) begin
                            state_d = StHalt;
                        end else if (jump_en_i) begin
                            state_d = StFetch;
                            pc_d    = jump_target_i;
                        end else begin
                            state_d = StFetch;
                            pc_d    = pc_inc(pc_q);
                        end
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StOff;
                    pc_d    = ResetVector;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StOff;
            pc_q          <= ResetVector;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign fetch_req_o   = (state_q == StFetch);
    assign fetch_addr_o  = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign state_o       = state_q;
    assign halted_o      = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: behavioural model with per-cycle compare plus literal checkpoints.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pwr = 1'b0;
    logic        mem = 1'b0;
    logic        exd = 1'b0;
    logic        jen = 1'b0;
    logic        hlt = 1'b0;
    logic [15:0] tgt = 16'h0000;

    logic        fetch_req, instr_valid, halted, fetch_fault;
    logic [15:0] fetch_addr, pc;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    pc_sequencer u_dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .is_powered_on_i (pwr),
        .mem_ready_i     (mem),
        .exec_done_i     (exd),
        .jump_en_i       (jen),
        .jump_target_i   (tgt),
        .halt_i          (hlt),
        .fetch_req_o     (fetch_req),
        .fetch_addr_o    (fetch_addr),
        .instr_valid_o   (instr_valid),
        .pc_o            (pc),
        .state_o         (state),
        .halted_o        (halted),
        .fetch_fault_o   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Phase numbers: 0 off, 1 fetch, 2 exec, 3 halt.
    int          m_phase;
    logic [15:0] m_pc;
    bit          m_fresh;
    bit          m_fault;
    int          m_stall;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_pc    <= 16'h0000;
            m_fresh <= 1'b0;
            m_fault <= 1'b0;
            m_stall <= 0;
        end else begin
            m_fresh <= 1'b0;
            if (!pwr) begin
                m_phase <= 0;
                m_pc    <= 16'h0000;
                m_fault <= 1'b0;
            end else if (m_phase == 0) begin
                m_phase <= 1;
                m_stall <= 0;
            end else if (m_phase == 1) begin
                if (mem) begin
                    m_phase <= 2;
                    m_fresh <= 1'b1;
                end else begin
                    m_stall <= m_stall + 1;
`ifdef PC_SEQ_WATCHDOG_EN
                    if (m_stall + 1 == 16) begin
                        m_phase <= 3;
                        m_fault <= 1'b1;
                    end
`endif
                end
            end else if (m_phase == 2 && exd) begin
                m_stall <= 0;
                if (hlt) begin
                    m_phase <= 3;
                end else if (jen) begin
                    m_phase <= 1;
                    m_pc    <= tgt;
                end else begin
                    m_phase <= 1;
                    m_pc    <= m_pc + 16'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("state", 32'(state), 32'(m_phase));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("fetch_addr", 32'(fetch_addr), 32'(m_pc));
            chk("fetch_req", 32'(fetch_req), 32'(m_phase == 1));
            chk("instr_valid", 32'(instr_valid), 32'(m_fresh));
            chk("halted", 32'(halted), 32'(m_phase == 3));
            chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);

        // Back-to-back instructions at full rate
        reset_n = 1'b1; pwr = 1'b1; mem = 1'b1; exd = 1'b1;
        step(6);
        chk("run_state", 32'(state), 32'd2);
        chk("run_pc", 32'(pc), 32'd2);
        chk("run_iv", 32'(instr_valid), 32'd1);
        pwr = 1'b0;
        step(1);
        chk("off_pc", 32'(pc), 32'd0);

        // Fetch stall
        pwr = 1'b1; mem = 1'b0; exd = 1'b0;
        step(6);
        chk("stall_state", 32'(state), 32'd1);
        chk("stall_req", 32'(fetch_req), 32'd1);
        mem = 1'b1;
        step(1);
        chk("stall_iv", 32'(instr_valid), 32'd1);
        mem = 1'b0;
        step(2);
        chk("exec_hold_iv", 32'(instr_valid), 32'd0);
        chk("exec_hold_state", 32'(state), 32'd2);

        // Jump to the top of memory, then wrap
        exd = 1'b1; jen = 1'b1; tgt = 16'hFFFF;
        step(1);
        chk("jump_pc", 32'(pc), 32'h0000_FFFF);
        exd = 1'b0; jen = 1'b0; mem = 1'b1;
        step(1);
        mem = 1'b0; exd = 1'b1;
        step(1);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_state", 32'(state), 32'd1);

        // Halt outranks jump
        mem = 1'b1; exd = 1'b0;
        step(1);
        exd = 1'b1; jen = 1'b1; tgt = 16'h0042; mem = 1'b0;
        step(1);
        mem = 1'b1; exd = 1'b0; jen = 1'b0;
        step(1);
        exd = 1'b1; hlt = 1'b1; jen = 1'b1; tgt = 16'h1234;
        step(1);
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_pc", 32'(pc), 32'h42);
        step(3);
        chk("halt_hold_pc", 32'(pc), 32'h42);
        chk("halt_hold_flag", 32'(halted), 32'd1);
        pwr = 1'b0; exd = 1'b0; hlt = 1'b0; jen = 1'b0; mem = 1'b0;
        step(1);
        chk("halt_off_state", 32'(state), 32'd0);
        chk("halt_off_pc", 32'(pc), 32'd0);

        // Power-off beats a simultaneous jump
        pwr = 1'b1; mem = 1'b1;
        step(2);
        pwr = 1'b0; exd = 1'b1; jen = 1'b1; tgt = 16'h5555; mem = 1'b0;
        step(1);
        chk("pwroff_state", 32'(state), 32'd0);
        chk("pwroff_pc", 32'(pc), 32'd0);

        // Long fetch stall (watchdog boundary)
        pwr = 1'b1; exd = 1'b0; jen = 1'b0;
        step(1);
        step(16);
`ifdef PC_SEQ_WATCHDOG_EN
        chk("wd_state", 32'(state), 32'd3);
        chk("wd_fault", 32'(fetch_fault), 32'd1);
`else
        chk("wd_state", 32'(state), 32'd1);
        chk("wd_fault", 32'(fetch_fault), 32'd0);
`endif
        step(2);
        pwr = 1'b0;
        step(1);
        chk("wd_clear_fault", 32'(fetch_fault), 32'd0);

        // Asynchronous reset mid-EXEC
        pwr = 1'b1; mem = 1'b1;
        step(2);
        exd = 1'b1;
        step(1);
        exd = 1'b0;
        step(1);
        chk("pre_rst_pc", 32'(pc), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_iv", 32'(instr_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
